fsm_trace_mon: RTL
==================

Name: fsm_trace_mon

Overview:
- Passive downstream monitor for the 2-bit state code produced by the Fig. 5.19 sequence FSM.
- Samples the code every clock and keeps per-state dwell counters, a transition counter and the current run length.
- Checks every observed edge against the legal Fig. 5.19 transition graph and latches the first illegal edge.
- Feeds bench scoreboards and on-chip debug readout; never drives the FSM.

Parameters:
- CNT_W, 16: width of all counters; every counter saturates at 2^CNT_W-1.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  asynchronous active-low reset.
- state_i  input  2  FSM state code: S0=00, S1=01, S2=10, S3=11.
- clr_i  input  1  synchronous clear of all counters and flags.
- sel_i  input  2  selects which per-state dwell counter drives dwell_o.
- dwell_o  output  CNT_W  dwell count of state sel_i.
- trans_cnt_o  output  CNT_W  number of state changes observed.
- run_len_o  output  CNT_W  consecutive cycles in the current state, including the present sample.
- illegal_o  output  1  sticky flag: an illegal edge has been seen.
- ill_from_o  output  2  source state of the first illegal edge.
- ill_to_o  output  2  destination state of the first illegal edge.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Clears all four dwell counters, trans_cnt, run_len, illegal, ill_from, ill_to and prev_valid; outputs read 0 immediately.
  - The reset state is held while rst_i=0.
- Internal registers: prev_state[1:0] and prev_valid.
  - prev_valid is 0 after reset or clear and becomes 1 after the first counted sample.
- Each posedge with clr_i=0 (a counted sample):
  - dwell[state_i] += 1, saturating; the other dwell counters hold.
  - If prev_valid=0: run_len <= 1; no edge check and no transition count.
  - If prev_valid=1 and state_i==prev_state: run_len += 1, saturating.
  - If prev_valid=1 and state_i!=prev_state: trans_cnt += 1 (saturating) and run_len <= 1.
  - prev_state <= state_i; prev_valid <= 1.
- Legal edges, including self-loops:
  - S0->{S0,S1}
  - S1->{S2,S3}
  - S2->{S2,S3}
  - S3->{S3,S0}
- Any other edge with prev_valid=1 is illegal:
  - If illegal=0: illegal <= 1, ill_from <= prev_state, ill_to <= state_i.
  - If illegal=1: ill_from and ill_to hold, so the first error is preserved.
  - Counting continues normally after an illegal edge.
- clr_i=1 at a posedge:
  - Same effect as reset, but synchronous.
  - The sample in that cycle is not counted and clr_i takes priority over all updates.
  - The next cycle is treated as a first sample (prev_valid=0).
- Saturation:
  - A counter at 2^CNT_W-1 holds; there is no wrap.
  - Saturation of one counter does not affect the others.
- Latency:
  - All counters and flags reflect a sample one cycle after the posedge that captured it.
  - dwell_o is a combinational mux of the registered counters by sel_i: zero-cycle select-to-output.
- An S1->S1 self-loop is illegal per Fig. 5.19 (S1 always exits) and must be flagged.

Decomposition:
- Shared package fsm519_pkg holds:
  - state code constants S0..S3.
  - function is_legal_edge(from, to) implementing the table above, shared with the FSM testbench.
- Sub-module sat_cnt (parameter W; ports clk_i, rst_i, clr_i, inc_i, load1_i, q_o):
  - Saturating counter with synchronous clear and load-to-1.
  - Instantiated six times: four dwell counters, trans_cnt and run_len.
  - Clear takes priority over load-to-1, which takes priority over increment.

Test Plan:
- Reset then feed S0,S0,S1,S2,S2,S3,S0 (7 clocks) -> dwell S0=3, S1=1, S2=2, S3=1; trans_cnt=4; run_len=1; illegal=0.
- From S0 feed S0->S2 -> illegal=1, ill_from=00, ill_to=10; a later S3->S1 leaves ill_from/ill_to unchanged; trans_cnt still increments.
- Feed S1,S1 after reset -> illegal=1, ill_from=01, ill_to=01, trans_cnt=0, run_len=2.
- CNT_W=4, hold S3 for 20 clocks -> dwell S3=15 and run_len=15, holding; other counters remain 0.
- Assert clr_i for one cycle mid-run, then feed S2 -> the clr cycle is not counted; after S2: dwell S2=1, trans_cnt=0, run_len=1, no illegal flag despite the previous state.
- Pull rst_i low between clock edges -> all outputs 0 before the next posedge; sweep sel_i 0..3 in one cycle -> dwell_o tracks each selected counter the same cycle.

Source files
------------

// File: rtl/fsm519_pkg.sv
// Shared definitions for the Fig. 5.19 sequence FSM: state codes and the
// legal-edge table used by both the trace monitor and the FSM bench.
package fsm519_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // Self-loops count as edges; S1 must always exit, so S1->S1 is illegal.
  function automatic logic is_legal_edge(input logic [1:0] from, input logic [1:0] to);
    logic ok;
    ok = 1'b0;
    case (from)
      S0: ok = (to == S0) || (to == S1);
      S1: ok = (to == S2) || (to == S3);
      S2: ok = (to == S2) || (to == S3);
      S3: ok = (to == S3) || (to == S0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear and load-to-1.
// Priority: clear, then load-to-1, then increment.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         load1_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  // Count register; holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_o <= '0;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (load1_i) begin
      q_o <= ONE;
    end else if (inc_i && (q_o != MAX)) begin
      q_o <= q_o + ONE;
    end
  end

endmodule

// File: rtl/fsm_trace_mon.sv
// Passive monitor for the Fig. 5.19 FSM state code: per-state dwell
// counters, transition count, current run length and first-illegal-edge
// capture. It only observes state_i and never feeds back into the FSM.
module fsm_trace_mon
  import fsm519_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       state_i,
  input  logic             clr_i,
  input  logic [1:0]       sel_i,
  output logic [CNT_W-1:0] dwell_o,
  output logic [CNT_W-1:0] trans_cnt_o,
  output logic [CNT_W-1:0] run_len_o,
  output logic             illegal_o,
  output logic [1:0]       ill_from_o,
  output logic [1:0]       ill_to_o
);

  logic [1:0]       prev_state;
  logic             prev_valid;
  logic             counted;
  logic             edge_seen;
  logic             same_state;
  logic             bad_edge;
  logic [CNT_W-1:0] dwell_q [4];

  // Classify the current sample against the previous one.
  always_comb begin
    counted    = !clr_i;
    edge_seen  = counted && prev_valid;
    same_state = (state_i == prev_state);
    bad_edge   = edge_seen && !is_legal_edge(prev_state, state_i);
  end

  for (genvar g = 0; g < 4; g++) begin : g_dwell
    sat_cnt #(.W(CNT_W)) u_dwell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr_i),
      .inc_i   (counted && (state_i == 2'(g))),
      .load1_i (1'b0),
      .q_o     (dwell_q[g])
    );
  end

  sat_cnt #(.W(CNT_W)) u_trans (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .inc_i   (edge_seen && !same_state),
    .load1_i (1'b0),
    .q_o     (trans_cnt_o)
  );

  // A first sample or a state change restarts the run at 1.
  sat_cnt #(.W(CNT_W)) u_run (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .inc_i   (edge_seen && same_state),
    .load1_i (counted && (!prev_valid || !same_state)),
    .q_o     (run_len_o)
  );

  // Previous-sample tracking; clear forces the next sample to be a first sample.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_state <= S0;
      prev_valid <= 1'b0;
    end else if (clr_i) begin
      prev_state <= S0;
      prev_valid <= 1'b0;
    end else begin
      prev_state <= state_i;
      prev_valid <= 1'b1;
    end
  end

  // Sticky illegal flag; only the first offending edge is recorded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_o  <= 1'b0;
      ill_from_o <= 2'b00;
      ill_to_o   <= 2'b00;
    end else if (clr_i) begin
      illegal_o  <= 1'b0;
      ill_from_o <= 2'b00;
      ill_to_o   <= 2'b00;
    end else if (bad_edge && !illegal_o) begin
      illegal_o  <= 1'b1;
      ill_from_o <= prev_state;
      ill_to_o   <= state_i;
    end
  end

  // Zero-latency readout of the selected dwell counter.
  always_comb begin
    dwell_o = dwell_q[sel_i];
  end

endmodule
